// File: rtl/seq_det_pkg.sv
// Shared constants, state type and sizing helper for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int unsigned PAT_W_MAX = 16;
    localparam int unsigned PAT_W_DEF = 3;
    localparam logic [PAT_W_MAX-1:0] PAT_RST_DEF = 16'h0003;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } det_state_e;

    // Smallest r with 2**r >= v; sizes the fill counter so it can hold PAT_W-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_param_sat_cnt.sv
// Width-parameterised saturating up-counter with synchronous reset and clear.
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised Mealy serial-pattern detector with runtime pattern reload and clear.
// Define SEQ_DET_MATCH_CNT_EN to add the saturating match_cnt output.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W_MAX-1:0] PAT_RST = PAT_RST_DEF,
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_vld,
    input  logic             din,
    input  logic             clr,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             dout
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    // Reject illegal configurations at elaboration.
    if ((PAT_W < 2) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_det_param: PAT_W=%0d outside 2..%0d", PAT_W, PAT_W_MAX);
    end
    if ((PAT_RST >> PAT_W) != '0) begin : g_bad_pat_rst
        $error("seq_det_param: PAT_RST wider than PAT_W=%0d", PAT_W);
    end
    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
        $error("seq_det_param: CNT_W=%0d outside 1..32", CNT_W);
    end

    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-1:0]  pat_nxt;
    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic              match;
    det_state_e        state;

    // The fill count is the state register; ARMED once PAT_W-1 bits of history exist.
    assign state = (fill == FILL_MAX) ? ST_ARMED : ST_FILL;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= PAT_W'(PAT_RST);
            hist  <= '0;
            fill  <= '0;
        end else begin
            pat_r <= pat_nxt;
            hist  <= hist_nxt;
            fill  <= fill_nxt;
        end
    end

    // Next-state and Mealy output; pat_load outranks clr, which outranks data.
    always_comb begin
        pat_nxt  = pat_r;
        hist_nxt = hist;
        fill_nxt = fill;
        match    = 1'b0;

        if (pat_load) begin
            pat_nxt  = pat_in;
            fill_nxt = '0;
        end else if (clr) begin
            fill_nxt = '0;
        end else if (din_vld) begin
            match = (state == ST_ARMED) && ({hist, din} == pat_r);
            if (match && !OVERLAP) begin
                fill_nxt = '0;
            end else begin
                hist_nxt = HIST_W'({hist, din});
                if (state == ST_FILL) begin
                    fill_nxt = fill + FILL_W'(1);
                end
            end
        end

        dout = match & ~reset;
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    sat_cnt #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .inc  (dout),
        .cnt  (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench: five detector configurations share one stimulus stream and a queue-based reference model.
`timescale 1ns/1ps
module tb_seq_det_param;

    localparam int N  = 5;
    localparam int CW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        din_vld;
    logic        din;
    logic        clr;
    logic        pat_load;
    logic [15:0] pat_in;
    logic [N-1:0] dout;
    logic [CW-1:0] mc [N];

    always #5 clk = ~clk;

    seq_det_param #(.PAT_W(3), .PAT_RST(16'h0003), .OVERLAP(1'b1), .CNT_W(CW)) u_d0 (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .clr(clr),
        .pat_load(pat_load), .pat_in(pat_in[2:0]),
`ifdef SEQ_DET_MATCH_CNT_EN
        .match_cnt(mc[0]),
`endif
        .dout(dout[0]));

    seq_det_param #(.PAT_W(3), .PAT_RST(16'h0005), .OVERLAP(1'b1), .CNT_W(CW)) u_d1 (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .clr(clr),
        .pat_load(pat_load), .pat_in(pat_in[2:0]),
`ifdef SEQ_DET_MATCH_CNT_EN
        .match_cnt(mc[1]),
`endif
        .dout(dout[1]));

    seq_det_param #(.PAT_W(3), .PAT_RST(16'h0005), .OVERLAP(1'b0), .CNT_W(CW)) u_d2 (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .clr(clr),
        .pat_load(pat_load), .pat_in(pat_in[2:0]),
`ifdef SEQ_DET_MATCH_CNT_EN
        .match_cnt(mc[2]),
`endif
        .dout(dout[2]));

    seq_det_param #(.PAT_W(5), .PAT_RST(16'h0016), .OVERLAP(1'b0), .CNT_W(CW)) u_d3 (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .clr(clr),
        .pat_load(pat_load), .pat_in(pat_in[4:0]),
`ifdef SEQ_DET_MATCH_CNT_EN
        .match_cnt(mc[3]),
`endif
        .dout(dout[3]));

    seq_det_param #(.PAT_W(2), .PAT_RST(16'h0002), .OVERLAP(1'b1), .CNT_W(CW)) u_d4 (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .clr(clr),
        .pat_load(pat_load), .pat_in(pat_in[1:0]),
`ifdef SEQ_DET_MATCH_CNT_EN
        .match_cnt(mc[4]),
`endif
        .dout(dout[4]));

    // Reference model: per instance, a list of accepted bits since the last restart.
    int          pw   [N] = '{3, 3, 3, 5, 2};
    logic [15:0] prst [N] = '{16'h0003, 16'h0005, 16'h0005, 16'h0016, 16'h0002};
    bit          ovl  [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] pat  [N];
    bit          bits [N][$];
    int          cnt  [N];
    bit          cnt_known = 1'b0;
    int          cyc_n = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct packed {
        logic [N-1:0]         dout;
        logic [N-1:0][CW-1:0] cnt;
        logic                 chk_cnt;
        logic [31:0]          tag;
    } exp_t;

    exp_t sb [$];

    task automatic model_cycle(output exp_t e);
        bit          m;
        logic [15:0] v;
        logic [15:0] msk;
        e.tag     = 32'(cyc_n);
        e.chk_cnt = cnt_known;
        e.dout    = '0;
        for (int i = 0; i < N; i++) e.cnt[i] = CW'(cnt[i]);
        for (int i = 0; i < N; i++) begin
            m = 1'b0;
            if (reset) begin
                pat[i] = prst[i];
                bits[i].delete();
            end else if (pat_load) begin
                msk    = 16'((32'd1 << pw[i]) - 1);
                pat[i] = pat_in & msk;
                bits[i].delete();
            end else if (clr) begin
                bits[i].delete();
            end else if (din_vld) begin
                bits[i].push_back(din);
                if (bits[i].size() >= pw[i]) begin
                    v = '0;
                    for (int k = bits[i].size() - pw[i]; k < bits[i].size(); k++)
                        v = {v[14:0], bits[i][k]};
                    m = (v == pat[i]);
                end
                if (m && !ovl[i]) bits[i].delete();
                while (bits[i].size() > pw[i] - 1) void'(bits[i].pop_front());
            end
            e.dout[i] = m;
            if (reset || clr) cnt[i] = 0;
            else if (m && cnt[i] < (1 << CW) - 1) cnt[i] = cnt[i] + 1;
        end
        if (reset || clr) cnt_known = 1'b1;
    endtask

    task automatic cyc(input bit r, input bit ld, input logic [15:0] pi,
                       input bit c, input bit vld, input bit d);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = r;
        pat_load = ld;
        pat_in   = pi;
        clr      = c;
        din_vld  = vld;
        din      = d;
        cyc_n    = cyc_n + 1;
        model_cycle(e);
        sb.push_back(e);
    endtask

    task automatic bitv(input bit d);           cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, d); endtask
    task automatic gap();                       cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'($urandom)); endtask
    task automatic do_clr(input bit d);         cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, d); endtask
    task automatic do_load(input logic [15:0] p); cyc(1'b0, 1'b1, p, 1'b0, 1'b1, 1'b1); endtask
    task automatic do_rst();                    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1); endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < N; i++) begin
                    checks = checks + 1;
                    if (dout[i] !== e.dout[i]) begin
                        errors = errors + 1;
                        $display("FAIL dout inst%0d cycle %0d: got %b expected %b",
                                 i, e.tag, dout[i], e.dout[i]);
                    end
`ifdef SEQ_DET_MATCH_CNT_EN
                    if (e.chk_cnt) begin
                        checks = checks + 1;
                        if (mc[i] !== e.cnt[i]) begin
                            errors = errors + 1;
                            $display("FAIL match_cnt inst%0d cycle %0d: got %0d expected %0d",
                                     i, e.tag, mc[i], e.cnt[i]);
                        end
                    end
`endif
                end
            end
        end
    end

    initial begin : stim
        bit r, ld, c, v;
        reset = 1'b1; pat_load = 1'b0; pat_in = '0; clr = 1'b0; din_vld = 1'b0; din = 1'b0;
        do_rst(); do_rst();
        // 0,1,1 then 1,1,0,1,1
        bitv(0); bitv(1); bitv(1);
        bitv(1); bitv(1); bitv(0); bitv(1); bitv(1);
        // 1,0,1,0,1 for overlapping vs non-overlapping 101
        do_clr(0);
        bitv(1); bitv(0); bitv(1); bitv(0); bitv(1);
        // valid gaps
        do_clr(0);
        bitv(0); gap(); gap(); bitv(1); gap(); bitv(1); gap(); gap();
        // clr in the middle, then clr on the matching bit
        do_clr(0);
        bitv(0); bitv(1); do_clr(0); bitv(1);
        bitv(0); bitv(1); bitv(1);
        bitv(0); bitv(1); do_clr(1);
        // runtime reload to 110 (and wider variants for the other instances)
        bitv(0); bitv(1); do_load(16'h0006);
        bitv(1); bitv(1); bitv(0);
        bitv(0); bitv(1); bitv(1);
        // reset mid-stream restores the power-on pattern
        bitv(0); bitv(1); do_rst(); bitv(1);
        bitv(0); bitv(1); bitv(1);
        // saturating match counter on an all-ones pattern
        do_clr(0); do_load(16'hFFFF);
        for (int k = 0; k < 7; k++) bitv(1);
        do_clr(1); bitv(1);
        // randomized traffic
        do_rst();
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 59) == 0);
            c  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 8);
            cyc(r, ld, 16'($urandom), c, v, 1'($urandom));
        end
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
